// File: rtl/fp_stream_pkg.sv
// +----------------------------------------------------------------------+
// | fp_stream_pkg : shared constants and FSM state type for the sample   |
// | streamer.   Revision: 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

package fp_stream_pkg;

  localparam int          FP_EXP_MSB      = 30;
  localparam int          FP_EXP_LSB      = 23;
  localparam logic [7:0]  FP_EXP_ALL_ONES = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO     = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fp_sample_ram.sv
// +----------------------------------------------------------------------+
// | fp_sample_ram : simple dual-port sample RAM, synchronous write and   |
// | 1-cycle synchronous read.   Revision: 1.0                           |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_sample_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fp_sample_streamer.sv
// +----------------------------------------------------------------------+
// | fp_sample_streamer : loadable binary32 sample buffer played out as a |
// | paced valid/data stream. Option FP_STREAM_SANITIZE_EN zeroes Inf/NaN.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_sample_streamer
  import fp_stream_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [DIV_W-1:0]  rate_div_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              valid_out_o,
  output logic [DATA_W-1:0] data_out_o
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  state_e              state_q;
  logic [ADDR_W-1:0]   rd_idx_q;
  logic [DIV_W-1:0]    pace_q;
  logic [DIV_W-1:0]    rate_q;
  logic [ADDR_W:0]     len_q;
  logic                rd_valid_q;
  logic                valid_q;
  logic                done_q;
  logic [DATA_W-1:0]   data_q;

  logic                ram_we;
  logic                rd_issue;
  logic                rd_last;
  logic [ADDR_W:0]     len_sat;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   sample_d;

  // Host writes are only honoured while idle so the buffer is stable during playback.
  assign ram_we   = wr_en_i && (state_q == IDLE);
  assign rd_issue = (state_q == PLAY) && (pace_q == '0) && !abort_i;
  assign rd_last  = ({1'b0, rd_idx_q} == (len_q - (ADDR_W+1)'(1)));
  assign len_sat  = (len_i > LEN_MAX) ? LEN_MAX : len_i;

  fp_sample_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .re_i    (rd_issue),
    .raddr_i (rd_idx_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    sample_d = ram_rdata;
`ifdef FP_STREAM_SANITIZE_EN
    if (ram_rdata[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ALL_ONES) sample_d = FP_POS_ZERO;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_idx_q   <= '0;
      pace_q     <= '0;
      rate_q     <= '0;
      len_q      <= '0;
      rd_valid_q <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      done_q     <= 1'b0;
      valid_q    <= rd_valid_q;
      rd_valid_q <= rd_issue;
      if (rd_valid_q) data_q <= sample_d;

      if (abort_i) begin
        state_q    <= IDLE;
        rd_idx_q   <= '0;
        pace_q     <= '0;
        rd_valid_q <= 1'b0;
        valid_q    <= 1'b0;
        done_q     <= (state_q != IDLE);
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              if (len_i == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q  <= PLAY;
                rd_idx_q <= '0;
                pace_q   <= '0;
                len_q    <= len_sat;
                rate_q   <= rate_div_i;
              end
            end
          end
          PLAY: begin
            // The pacing counter reloads on every issued read.
            if (pace_q == '0) begin
              pace_q <= rate_q;
              if (rd_last) state_q <= DRAIN;
              else         rd_idx_q <= rd_idx_q + ADDR_W'(1);
            end else begin
              pace_q <= pace_q - DIV_W'(1);
            end
          end
          DRAIN: begin
            if (!rd_valid_q) begin
              state_q  <= IDLE;
              rd_idx_q <= '0;
              done_q   <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign valid_out_o = valid_q;
  assign data_out_o  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_sample_streamer.sv
// +----------------------------------------------------------------------+
// | tb_fp_sample_streamer : directed self-checking bench for the sample  |
// | streamer.   Revision: 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fp_sample_streamer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [10:0] len;
  logic [7:0]  rate_div;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        valid;
  logic [31:0] data_out;

  int n_total;
  int n_bad;
  logic [31:0] exp_mem [8];

  fp_sample_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .len_i       (len),
    .rate_div_i  (rate_div),
    .start_i     (start),
    .abort_i     (abort),
    .busy_o      (busy),
    .done_o      (done),
    .valid_out_o (valid),
    .data_out_o  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input int addr, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = 10'(addr); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic launch(input int n, input int rate);
    start = 1'b1; len = 11'(n); rate_div = 8'(rate);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes cycles T+1.. after a launch; optionally attempts a write while busy.
  task automatic play_check(input int n, input int rate, input bit bw);
    int t_done;
    int j;
    t_done = 2 + (n - 1) * (rate + 1) + 1;
    j = 0;
    if (bw) begin wr_en = 1'b1; wr_addr = 10'd1; wr_data = 32'h1234_5678; end
    for (int i = 1; i <= t_done + 1; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (i >= 2 && ((i - 2) % (rate + 1)) == 0 && j < n) begin
        chk("valid_hi", 32'(valid), 32'd1);
        chk("data", data_out, exp_mem[j]);
        j++;
      end else begin
        chk("valid_lo", 32'(valid), 32'd0);
      end
      chk("done", 32'(done), 32'(i == t_done));
      chk("busy", 32'(busy), 32'(i < t_done));
    end
  endtask

  initial begin
    int cnt;
    bit got_done;
    n_total = 0; n_bad = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; rate_div = '0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", data_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    exp_mem[0] = 32'h3F80_0000; exp_mem[1] = 32'h4000_0000; exp_mem[2] = 32'hBF80_0000;
    for (int a = 0; a < 3; a++) wr(a, exp_mem[a]);

    launch(3, 0); play_check(3, 0, 1'b0);
    launch(3, 2); play_check(3, 2, 1'b0);

    // len == 0: done next cycle, never valid
    launch(0, 0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len0_valid", 32'(valid), 32'd0);
      chk("len0_done2", 32'(done), 32'd0);
    end

    // start and abort together: abort wins, no done
    abort = 1'b1;
    launch(3, 0);
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sa_valid", 32'(valid), 32'd0);
    end

    // write while busy is dropped, then rerun shows original values
    launch(3, 3); play_check(3, 3, 1'b1);
    launch(3, 0); play_check(3, 0, 1'b0);

    // write and start in the same cycle: new value is played
    wr_en = 1'b1; wr_addr = 10'd0; wr_data = 32'h4040_0000;
    exp_mem[0] = 32'h4040_0000;
    launch(3, 0);
    wr_en = 1'b0;
    play_check(3, 0, 1'b0);

    // Inf/NaN samples
    wr(3, 32'h7FC0_0000);
    wr(4, 32'hFF80_0000);
`ifdef FP_STREAM_SANITIZE_EN
    exp_mem[3] = 32'h0000_0000; exp_mem[4] = 32'h0000_0000;
`else
    exp_mem[3] = 32'h7FC0_0000; exp_mem[4] = 32'hFF80_0000;
`endif
    launch(5, 1); play_check(5, 1, 1'b0);

    // abort on the 10th valid sample of a full-depth run
    launch(1024, 0);
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 10; i++) begin
      @(negedge clk);
      if (valid) cnt++;
    end
    chk("ab_cnt", 32'(cnt), 32'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", 32'(valid), 32'd0);
    chk("ab_done", 32'(done), 32'd1);
    chk("ab_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ab_quiet_v", 32'(valid), 32'd0);
      chk("ab_quiet_d", 32'(done), 32'd0);
    end
    launch(3, 0); play_check(3, 0, 1'b0);

    // len above DEPTH saturates to DEPTH samples
    launch(2047, 0);
    cnt = 0; got_done = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (valid) cnt++;
      if (done) begin got_done = 1'b1; break; end
    end
    chk("sat_done", 32'(got_done), 32'd1);
    chk("sat_cnt", 32'(cnt), 32'd1024);

    // reset mid-playback
    launch(3, 2);
    @(negedge clk); @(negedge clk);
    chk("mid_valid_pre", 32'(valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_valid", 32'(valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_v", 32'(valid), 32'd0);
      chk("post_rst_d", 32'(done), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
